// File: rtl/axi_sram_slv.sv
// AXI4 slave backed by a word-addressed SRAM: independent read/write engines,
// INCR/FIXED bursts, fixed read latency, SLVERR for illegal bursts, DECERR out of range.
module axi_sram_slv #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        slv_ar_valid_i,
  output logic        slv_ar_ready_o,
  input  logic [31:0] slv_ar_addr_i,
  input  logic [3:0]  slv_ar_id_i,
  input  logic [7:0]  slv_ar_len_i,
  input  logic [2:0]  slv_ar_size_i,
  input  logic [1:0]  slv_ar_burst_i,
  output logic        slv_r_valid_o,
  input  logic        slv_r_ready_i,
  output logic [31:0] slv_r_data_o,
  output logic [1:0]  slv_r_resp_o,
  output logic        slv_r_last_o,
  output logic [3:0]  slv_r_id_o,
  input  logic        slv_aw_valid_i,
  output logic        slv_aw_ready_o,
  input  logic [31:0] slv_aw_addr_i,
  input  logic [3:0]  slv_aw_id_i,
  input  logic [7:0]  slv_aw_len_i,
  input  logic [2:0]  slv_aw_size_i,
  input  logic [1:0]  slv_aw_burst_i,
  input  logic        slv_w_valid_i,
  output logic        slv_w_ready_o,
  input  logic [31:0] slv_w_data_i,
  input  logic [3:0]  slv_w_strb_i,
  input  logic        slv_w_last_i,
  output logic        slv_b_valid_o,
  input  logic        slv_b_ready_i,
  output logic [1:0]  slv_b_resp_o,
  output logic [3:0]  slv_b_id_o
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
  localparam logic [7:0]  LAT   = 8'(RD_LAT);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  logic [31:0] mem [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    return a < LIMIT;
  endfunction

  rd_state_t   rd_state, rd_next;
  logic [31:0] rd_addr, sel_addr, rd_word, beat_data;
  logic [7:0]  rd_len, rd_beat, rd_cnt, sel_beat, sel_len;
  logic        rd_fixed, rd_bad, sel_bad, rd_load, ar_hs, r_hs;
  logic [1:0]  beat_resp;

  assign ar_hs = slv_ar_valid_i & slv_ar_ready_o;
  assign r_hs  = slv_r_valid_o & slv_r_ready_i;

  // sel_* is the beat about to be registered onto R: straight from AR when
  // RD_LAT=0, otherwise from the captured burst state.
  always_comb begin
    rd_next  = rd_state;
    rd_load  = 1'b0;
    sel_addr = rd_addr;
    sel_beat = rd_beat;
    sel_len  = rd_len;
    sel_bad  = rd_bad;
    case (rd_state)
      R_IDLE: begin
        sel_addr = slv_ar_addr_i;
        sel_beat = 8'd0;
        sel_len  = slv_ar_len_i;
        sel_bad  = slv_ar_burst_i[1] | (slv_ar_size_i != 3'd2);
        if (ar_hs) begin
          rd_next = (RD_LAT == 0) ? R_DATA : R_WAIT;
          rd_load = (RD_LAT == 0);
        end
      end
      R_WAIT: begin
        sel_beat = 8'd0;
        if (rd_cnt == 8'd1) begin
          rd_next = R_DATA;
          rd_load = 1'b1;
        end
      end
      R_DATA: begin
        sel_addr = rd_fixed ? rd_addr : rd_addr + 32'd4;
        sel_beat = rd_beat + 8'd1;
        if (r_hs) begin
          if (slv_r_last_o) rd_next = R_IDLE;
          else              rd_load = 1'b1;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  assign rd_word   = mem[sel_addr[AW+1:2]];
  assign beat_resp = sel_bad ? 2'b10 : (in_range(sel_addr) ? 2'b00 : 2'b11);
  assign beat_data = (beat_resp == 2'b00) ? rd_word : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state       <= R_IDLE;
      slv_ar_ready_o <= 1'b0;
      slv_r_valid_o  <= 1'b0;
      slv_r_data_o   <= 32'd0;
      slv_r_resp_o   <= 2'b00;
      slv_r_last_o   <= 1'b0;
      slv_r_id_o     <= 4'd0;
      rd_addr        <= 32'd0;
      rd_len         <= 8'd0;
      rd_beat        <= 8'd0;
      rd_cnt         <= 8'd0;
      rd_fixed       <= 1'b0;
      rd_bad         <= 1'b0;
    end else begin
      rd_state       <= rd_next;
      slv_ar_ready_o <= (rd_next == R_IDLE);
      if (ar_hs) begin
        rd_addr    <= slv_ar_addr_i;
        rd_len     <= slv_ar_len_i;
        rd_fixed   <= (slv_ar_burst_i == 2'b00);
        rd_bad     <= sel_bad;
        rd_cnt     <= LAT;
        rd_beat    <= 8'd0;
        slv_r_id_o <= slv_ar_id_i;
      end else if (rd_state == R_WAIT) begin
        rd_cnt <= rd_cnt - 8'd1;
      end
      if (rd_load) begin
        rd_addr       <= sel_addr;
        rd_beat       <= sel_beat;
        slv_r_valid_o <= 1'b1;
        slv_r_data_o  <= beat_data;
        slv_r_resp_o  <= beat_resp;
        slv_r_last_o  <= (sel_beat == sel_len);
      end else if (r_hs) begin
        slv_r_valid_o <= 1'b0;
      end
    end
  end

  wr_state_t   wr_state, wr_next;
  logic [31:0] wr_addr;
  logic [7:0]  wr_len, wr_beat;
  logic [3:0]  wr_id;
  logic        wr_fixed, wr_bad, wr_oor, wr_lerr;
  logic        aw_hs, w_hs, b_hs, wr_last_beat, wr_in, wr_oor_nx, wr_lerr_nx;

  assign aw_hs        = slv_aw_valid_i & slv_aw_ready_o;
  assign w_hs         = slv_w_valid_i & slv_w_ready_o;
  assign b_hs         = slv_b_valid_o & slv_b_ready_i;
  assign wr_last_beat = (wr_beat == wr_len);
  assign wr_in        = in_range(wr_addr);
  assign wr_oor_nx    = wr_oor | ~wr_in;
  assign wr_lerr_nx   = wr_lerr | (slv_w_last_i != wr_last_beat);

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_hs) wr_next = W_DATA;
      W_DATA:  if (w_hs && wr_last_beat) wr_next = W_RESP;
      W_RESP:  if (b_hs) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state       <= W_IDLE;
      slv_aw_ready_o <= 1'b0;
      slv_w_ready_o  <= 1'b0;
      slv_b_valid_o  <= 1'b0;
      slv_b_resp_o   <= 2'b00;
      slv_b_id_o     <= 4'd0;
      wr_addr        <= 32'd0;
      wr_len         <= 8'd0;
      wr_beat        <= 8'd0;
      wr_id          <= 4'd0;
      wr_fixed       <= 1'b0;
      wr_bad         <= 1'b0;
      wr_oor         <= 1'b0;
      wr_lerr        <= 1'b0;
    end else begin
      wr_state       <= wr_next;
      slv_aw_ready_o <= (wr_next == W_IDLE);
      slv_w_ready_o  <= (wr_next == W_DATA);
      if (aw_hs) begin
        wr_addr  <= slv_aw_addr_i;
        wr_len   <= slv_aw_len_i;
        wr_id    <= slv_aw_id_i;
        wr_fixed <= (slv_aw_burst_i == 2'b00);
        wr_bad   <= slv_aw_burst_i[1] | (slv_aw_size_i != 3'd2);
        wr_beat  <= 8'd0;
        wr_oor   <= 1'b0;
        wr_lerr  <= 1'b0;
      end
      if (w_hs) begin
        wr_beat <= wr_beat + 8'd1;
        wr_addr <= wr_fixed ? wr_addr : wr_addr + 32'd4;
        wr_oor  <= wr_oor_nx;
        wr_lerr <= wr_lerr_nx;
        // Response folds in the final beat's own range and w_last status.
        if (wr_last_beat) begin
          slv_b_valid_o <= 1'b1;
          slv_b_id_o    <= wr_id;
          slv_b_resp_o  <= (wr_bad | wr_lerr_nx) ? 2'b10 : (wr_oor_nx ? 2'b11 : 2'b00);
        end
      end
      if (b_hs) slv_b_valid_o <= 1'b0;
    end
  end

  // Contents survive reset; an in-flight burst simply stops writing.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_hs && !wr_bad && wr_in) begin
      for (int b = 0; b < 4; b++) begin
        if (slv_w_strb_i[b]) mem[wr_addr[AW+1:2]][8*b +: 8] <= slv_w_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slv.sv
// Self-checking bench for axi_sram_slv: directed scenarios plus randomized
// bursts compared against an array-based memory/response model.
module tb_axi_sram_slv;

  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 1;
  localparam int AWB    = $clog2(DEPTH);

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        slv_ar_valid_i, slv_ar_ready_o;
  logic [31:0] slv_ar_addr_i;
  logic [3:0]  slv_ar_id_i;
  logic [7:0]  slv_ar_len_i;
  logic [2:0]  slv_ar_size_i;
  logic [1:0]  slv_ar_burst_i;
  logic        slv_r_valid_o, slv_r_ready_i;
  logic [31:0] slv_r_data_o;
  logic [1:0]  slv_r_resp_o;
  logic        slv_r_last_o;
  logic [3:0]  slv_r_id_o;
  logic        slv_aw_valid_i, slv_aw_ready_o;
  logic [31:0] slv_aw_addr_i;
  logic [3:0]  slv_aw_id_i;
  logic [7:0]  slv_aw_len_i;
  logic [2:0]  slv_aw_size_i;
  logic [1:0]  slv_aw_burst_i;
  logic        slv_w_valid_i, slv_w_ready_o;
  logic [31:0] slv_w_data_i;
  logic [3:0]  slv_w_strb_i;
  logic        slv_w_last_i;
  logic        slv_b_valid_o, slv_b_ready_i;
  logic [1:0]  slv_b_resp_o;
  logic [3:0]  slv_b_id_o;

  always #5 clk_i = ~clk_i;

  axi_sram_slv #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
    .slv_ar_addr_i(slv_ar_addr_i), .slv_ar_id_i(slv_ar_id_i), .slv_ar_len_i(slv_ar_len_i),
    .slv_ar_size_i(slv_ar_size_i), .slv_ar_burst_i(slv_ar_burst_i),
    .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready_i), .slv_r_data_o(slv_r_data_o),
    .slv_r_resp_o(slv_r_resp_o), .slv_r_last_o(slv_r_last_o), .slv_r_id_o(slv_r_id_o),
    .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
    .slv_aw_addr_i(slv_aw_addr_i), .slv_aw_id_i(slv_aw_id_i), .slv_aw_len_i(slv_aw_len_i),
    .slv_aw_size_i(slv_aw_size_i), .slv_aw_burst_i(slv_aw_burst_i),
    .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o), .slv_w_data_i(slv_w_data_i),
    .slv_w_strb_i(slv_w_strb_i), .slv_w_last_i(slv_w_last_i),
    .slv_b_valid_o(slv_b_valid_o), .slv_b_ready_i(slv_b_ready_i),
    .slv_b_resp_o(slv_b_resp_o), .slv_b_id_o(slv_b_id_o)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_strb_q[$];
  logic        wr_last_q[$];
  // Read beats packed as {resp, last, id, data}.
  logic [38:0] rd_q[$];
  logic [38:0] exp_q[$];
  int          rd_lat, rd_gaps, rd_unstable;
  logic        rd_arready_after;

  function automatic void push_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    wr_data_q.push_back(d);
    wr_strb_q.push_back(s);
    wr_last_q.push_back(l);
  endfunction

  function automatic void clear_beats();
    wr_data_q.delete();
    wr_strb_q.delete();
    wr_last_q.delete();
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [1:0] burst, input logic [2:0] size);
    logic bad, lerr, oor;
    logic [31:0] a;
    bad  = (burst > 2'd1) || (size != 3'd2);
    lerr = 1'b0;
    oor  = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = (burst == 2'd0) ? addr : addr + 32'(4 * i);
      if (wr_last_q[i] != (i == int'(len))) lerr = 1'b1;
      if (a >= 32'(DEPTH * 4)) oor = 1'b1;
      else if (!bad)
        for (int b = 0; b < 4; b++)
          if (wr_strb_q[i][b]) model_mem[a[AWB+1:2]][8*b +: 8] = wr_data_q[i][8*b +: 8];
    end
    if (bad || lerr) return 2'b10;
    if (oor) return 2'b11;
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                                     input logic [1:0] burst, input logic [2:0] size);
    logic [31:0] a, d;
    logic [1:0]  r;
    exp_q.delete();
    for (int i = 0; i <= int'(len); i++) begin
      a = (burst == 2'd0) ? addr : addr + 32'(4 * i);
      if ((burst > 2'd1) || (size != 3'd2)) begin r = 2'b10; d = 32'd0; end
      else if (a >= 32'(DEPTH * 4))         begin r = 2'b11; d = 32'd0; end
      else                                  begin r = 2'b00; d = model_mem[a[AWB+1:2]]; end
      exp_q.push_back({r, (i == int'(len)), id, d});
    end
  endfunction

  task automatic timeout_fail(input string what, input int cycles);
    checks++;
    failures++;
    $display("[TB] FAIL %s: no handshake after %0d cycles, required within bound", what, cycles);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          output logic [1:0] bresp, output logic [3:0] bid);
    logic hs;
    int guard;
    bresp = 2'bxx;
    bid   = 4'bxxxx;
    slv_aw_addr_i = addr; slv_aw_id_i = id; slv_aw_len_i = len;
    slv_aw_burst_i = burst; slv_aw_size_i = size; slv_aw_valid_i = 1'b1;
    guard = 0;
    do begin hs = slv_aw_ready_o; @(posedge clk_i); #1; guard++; end while (!hs && guard < 100);
    slv_aw_valid_i = 1'b0;
    if (!hs) begin timeout_fail("aw_handshake", guard); return; end
    for (int i = 0; i <= int'(len); i++) begin
      slv_w_data_i = wr_data_q[i]; slv_w_strb_i = wr_strb_q[i]; slv_w_last_i = wr_last_q[i];
      slv_w_valid_i = 1'b1;
      guard = 0;
      do begin hs = slv_w_ready_o; @(posedge clk_i); #1; guard++; end while (!hs && guard < 100);
      if (!hs) begin slv_w_valid_i = 1'b0; timeout_fail("w_handshake", guard); return; end
    end
    slv_w_valid_i = 1'b0;
    slv_b_ready_i = 1'b1;
    guard = 0;
    do begin
      hs = slv_b_valid_o;
      if (hs) begin bresp = slv_b_resp_o; bid = slv_b_id_o; end
      @(posedge clk_i); #1; guard++;
    end while (!hs && guard < 100);
    slv_b_ready_i = 1'b0;
    if (!hs) timeout_fail("b_handshake", guard);
  endtask

  // rpat bit k drives r_ready in the k-th cycle after the AR handshake.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input logic [31:0] rpat);
    logic hs, rr, done, seen, prev_stall;
    logic [38:0] cur, prev;
    int guard, k;
    rd_q.delete();
    rd_lat = -1; rd_gaps = 0; rd_unstable = 0;
    slv_ar_addr_i = addr; slv_ar_id_i = id; slv_ar_len_i = len;
    slv_ar_burst_i = burst; slv_ar_size_i = size; slv_ar_valid_i = 1'b1;
    guard = 0;
    do begin hs = slv_ar_ready_o; @(posedge clk_i); #1; guard++; end while (!hs && guard < 100);
    slv_ar_valid_i = 1'b0;
    if (!hs) begin timeout_fail("ar_handshake", guard); return; end
    rd_arready_after = slv_ar_ready_o;
    done = 1'b0; seen = 1'b0; prev_stall = 1'b0; prev = '0; k = 0;
    while (!done && k < 2000) begin
      rr = (k < 32) ? rpat[k] : 1'b1;
      slv_r_ready_i = rr;
      cur = {slv_r_resp_o, slv_r_last_o, slv_r_id_o, slv_r_data_o};
      if (prev_stall && (!slv_r_valid_o || cur != prev)) rd_unstable++;
      if (slv_r_valid_o) begin
        if (!seen) rd_lat = k + 1;
        seen = 1'b1;
        if (rr) begin rd_q.push_back(cur); if (slv_r_last_o) done = 1'b1; end
      end else if (seen) begin
        rd_gaps++;
      end
      prev_stall = slv_r_valid_o && !rr;
      prev = cur;
      @(posedge clk_i); #1; k++;
    end
    slv_r_ready_i = 1'b0;
    if (!done) timeout_fail("r_last", k);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({slv_ar_ready_o, slv_r_valid_o, slv_r_data_o, slv_r_resp_o, slv_r_last_o, slv_r_id_o,
         slv_aw_ready_o, slv_w_ready_o, slv_b_valid_o, slv_b_resp_o, slv_b_id_o} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got nonzero outputs ar_ready=%b r_valid=%b aw_ready=%b w_ready=%b b_valid=%b, required all 0",
               slv_ar_ready_o, slv_r_valid_o, slv_aw_ready_o, slv_w_ready_o, slv_b_valid_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if ({slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o, slv_r_valid_o, slv_b_valid_o} !== 5'b11000) begin
      failures++;
      $display("[TB] FAIL after_reset_ready: got %b, required 11000",
               {slv_ar_ready_o, slv_aw_ready_o, slv_w_ready_o, slv_r_valid_o, slv_b_valid_o});
    end
  endtask

  task automatic test_fill();
    logic [1:0] br, exp;
    logic [3:0] bi;
    for (int blk = 0; blk < 4; blk++) begin
      clear_beats();
      for (int i = 0; i < 256; i++) push_beat($urandom, 4'hF, i == 255);
      exp = model_write(32'(blk * 1024), 8'd255, 2'b01, 3'd2);
      do_write(32'(blk * 1024), 4'(blk), 8'd255, 2'b01, 3'd2, br, bi);
      checks++;
      if ({br, bi} !== {exp, 4'(blk)}) begin
        failures++;
        $display("[TB] FAIL fill_bresp: got resp=%b id=%h, required resp=%b id=%h", br, bi, exp, 4'(blk));
      end
    end
  endtask

  task automatic test_single_read();
    logic [1:0] br, exp;
    logic [3:0] bi;
    clear_beats();
    push_beat(32'hDEADBEEF, 4'hF, 1'b1);
    exp = model_write(32'h10, 8'd0, 2'b01, 3'd2);
    do_write(32'h10, 4'h1, 8'd0, 2'b01, 3'd2, br, bi);
    checks++;
    if (br !== exp) begin failures++; $display("[TB] FAIL preload_bresp: got %b, required %b", br, exp); end
    do_read(32'h10, 4'hA, 8'd0, 2'b01, 3'd2, 32'hFFFFFFFF);
    checks++;
    if (rd_q.size() != 1 || rd_q[0] !== {2'b00, 1'b1, 4'hA, 32'hDEADBEEF}) begin
      failures++;
      $display("[TB] FAIL single_read_beat: got %0d beats first=%h, required 1 beat %h",
               rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 39'h0, {2'b00, 1'b1, 4'hA, 32'hDEADBEEF});
    end
    checks++;
    if (rd_lat != 1 + RD_LAT) begin failures++; $display("[TB] FAIL read_latency: got %0d, required %0d", rd_lat, 1 + RD_LAT); end
    checks++;
    if (rd_arready_after !== 1'b0) begin failures++; $display("[TB] FAIL ar_ready_drop: got %b, required 0", rd_arready_after); end
  endtask

  task automatic test_incr_write_read();
    logic [1:0] br;
    logic [3:0] bi;
    clear_beats();
    for (int i = 0; i < 4; i++) push_beat(32'(i + 1), 4'hF, i == 3);
    void'(model_write(32'h20, 8'd3, 2'b01, 3'd2));
    do_write(32'h20, 4'h5, 8'd3, 2'b01, 3'd2, br, bi);
    checks++;
    if ({br, bi} !== {2'b00, 4'h5}) begin failures++; $display("[TB] FAIL incr_bresp: got %b/%h, required 00/5", br, bi); end
    model_read(32'h20, 4'h6, 8'd3, 2'b01, 3'd2);
    do_read(32'h20, 4'h6, 8'd3, 2'b01, 3'd2, 32'hFFFFFFFF);
    checks++;
    if (rd_q.size() != 4) begin failures++; $display("[TB] FAIL incr_beat_count: got %0d, required 4", rd_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rd_q.size() || rd_q[i] !== exp_q[i] || exp_q[i][31:0] !== 32'(i + 1)) begin
        failures++;
        $display("[TB] FAIL incr_beat%0d: got %h, required %h", i, (i < rd_q.size()) ? rd_q[i] : 39'h0, exp_q[i]);
      end
    end
    checks++;
    if (rd_gaps != 0) begin failures++; $display("[TB] FAIL incr_back_to_back: got %0d bubbles, required 0", rd_gaps); end
  endtask

  task automatic test_fixed_strobe();
    logic [1:0] br;
    logic [3:0] bi;
    clear_beats();
    push_beat(32'h11223344, 4'hF, 1'b1);
    void'(model_write(32'h0, 8'd0, 2'b01, 3'd2));
    do_write(32'h0, 4'h2, 8'd0, 2'b01, 3'd2, br, bi);
    clear_beats();
    push_beat(32'hAAAAAAAA, 4'b0001, 1'b0);
    push_beat(32'hBBBBBBBB, 4'b1000, 1'b1);
    void'(model_write(32'h0, 8'd1, 2'b00, 3'd2));
    do_write(32'h0, 4'h3, 8'd1, 2'b00, 3'd2, br, bi);
    checks++;
    if (br !== 2'b00) begin failures++; $display("[TB] FAIL fixed_bresp: got %b, required 00", br); end
    do_read(32'h0, 4'h4, 8'd0, 2'b01, 3'd2, 32'hFFFFFFFF);
    checks++;
    if (rd_q.size() != 1 || rd_q[0][31:0] !== 32'hBB2233AA) begin
      failures++;
      $display("[TB] FAIL fixed_strobe_data: got %h, required bb2233aa", (rd_q.size() > 0) ? rd_q[0][31:0] : 32'h0);
    end
  endtask

  task automatic test_backpressure();
    model_read(32'h20, 4'h7, 8'd3, 2'b01, 3'd2);
    do_read(32'h20, 4'h7, 8'd3, 2'b01, 3'd2, 32'hFFFFFFE3);
    checks++;
    if (rd_q.size() != 4) begin failures++; $display("[TB] FAIL bp_beat_count: got %0d, required 4", rd_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rd_q.size() || rd_q[i] !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL bp_beat%0d: got %h, required %h", i, (i < rd_q.size()) ? rd_q[i] : 39'h0, exp_q[i]);
      end
    end
    checks++;
    if (rd_unstable != 0) begin failures++; $display("[TB] FAIL bp_stable: got %0d changes while stalled, required 0", rd_unstable); end
  endtask

  task automatic test_errors();
    logic [1:0] br;
    logic [3:0] bi;
    model_read(32'(DEPTH * 4 - 4), 4'h8, 8'd1, 2'b01, 3'd2);
    do_read(32'(DEPTH * 4 - 4), 4'h8, 8'd1, 2'b01, 3'd2, 32'hFFFFFFFF);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= rd_q.size() || rd_q[i] !== exp_q[i] || exp_q[i][38:37] !== ((i == 0) ? 2'b00 : 2'b11)) begin
        failures++;
        $display("[TB] FAIL oor_read_beat%0d: got %h, required %h", i, (i < rd_q.size()) ? rd_q[i] : 39'h0, exp_q[i]);
      end
    end
    clear_beats();
    push_beat($urandom, 4'hF, 1'b0);
    push_beat($urandom, 4'hF, 1'b1);
    void'(model_write(32'h30, 8'd1, 2'b10, 3'd2));
    do_write(32'h30, 4'h9, 8'd1, 2'b10, 3'd2, br, bi);
    checks++;
    if (br !== 2'b10) begin failures++; $display("[TB] FAIL illegal_burst_bresp: got %b, required 10", br); end
    model_read(32'h30, 4'h9, 8'd1, 2'b01, 3'd2);
    do_read(32'h30, 4'h9, 8'd1, 2'b01, 3'd2, 32'hFFFFFFFF);
    checks++;
    if (rd_q.size() != 2 || rd_q[0] !== exp_q[0] || rd_q[1] !== exp_q[1]) begin
      failures++;
      $display("[TB] FAIL illegal_burst_unchanged: got %h %h, required %h %h",
               (rd_q.size() > 0) ? rd_q[0] : 39'h0, (rd_q.size() > 1) ? rd_q[1] : 39'h0, exp_q[0], exp_q[1]);
    end
    clear_beats();
    push_beat($urandom, 4'hF, 1'b0);
    push_beat($urandom, 4'h0, 1'b1);
    push_beat($urandom, 4'h0, 1'b0);
    void'(model_write(32'h50, 8'd2, 2'b01, 3'd2));
    do_write(32'h50, 4'hB, 8'd2, 2'b01, 3'd2, br, bi);
    checks++;
    if (br !== 2'b10) begin failures++; $display("[TB] FAIL early_wlast_bresp: got %b, required 10", br); end
    model_read(32'h50, 4'hB, 8'd0, 2'b01, 3'd2);
    do_read(32'h50, 4'hB, 8'd0, 2'b01, 3'd2, 32'hFFFFFFFF);
    checks++;
    if (rd_q.size() != 1 || rd_q[0] !== exp_q[0]) begin
      failures++;
      $display("[TB] FAIL early_wlast_kept: got %h, required %h", (rd_q.size() > 0) ? rd_q[0] : 39'h0, exp_q[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int got, guard;
    slv_ar_addr_i = 32'h40; slv_ar_id_i = 4'h3; slv_ar_len_i = 8'd3;
    slv_ar_burst_i = 2'b01; slv_ar_size_i = 3'd2; slv_ar_valid_i = 1'b1;
    @(posedge clk_i); #1;
    slv_ar_valid_i = 1'b0;
    slv_r_ready_i = 1'b1;
    got = 0; guard = 0;
    while (guard < 50 && !(slv_r_valid_o && got == 1)) begin
      if (slv_r_valid_o) got++;
      @(posedge clk_i); #1; guard++;
    end
    rst_i = 1'b1;
    slv_r_ready_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if ({slv_r_valid_o, slv_ar_ready_o} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: got r_valid=%b ar_ready=%b after %0d beats, required 0 0", slv_r_valid_o, slv_ar_ready_o, got);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (slv_ar_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_release: got ar_ready=%b, required 1", slv_ar_ready_o); end
    model_read(32'h40, 4'hC, 8'd3, 2'b01, 3'd2);
    do_read(32'h40, 4'hC, 8'd3, 2'b01, 3'd2, 32'hFFFFFFFF);
    checks++;
    if (rd_q != exp_q) begin failures++; $display("[TB] FAIL mid_reset_reread: got %0d beats, required %0d matching beats", rd_q.size(), exp_q.size()); end
  endtask

  task automatic test_concurrent();
    logic [1:0] br, exp;
    logic [3:0] bi;
    clear_beats();
    for (int i = 0; i < 4; i++) push_beat($urandom, 4'hF, i == 3);
    exp = model_write(32'h100, 8'd3, 2'b01, 3'd2);
    model_read(32'h200, 4'hD, 8'd3, 2'b01, 3'd2);
    fork
      do_write(32'h100, 4'hE, 8'd3, 2'b01, 3'd2, br, bi);
      do_read(32'h200, 4'hD, 8'd3, 2'b01, 3'd2, 32'hFFFFFFFF);
    join
    checks++;
    if ({br, bi} !== {exp, 4'hE}) begin failures++; $display("[TB] FAIL concurrent_bresp: got %b/%h, required %b/e", br, bi, exp); end
    checks++;
    if (rd_q != exp_q) begin failures++; $display("[TB] FAIL concurrent_read: got %0d beats, required %0d matching beats", rd_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst, br, exp;
    logic [2:0]  size;
    logic [3:0]  id, bi;
    int sel;
    for (int n = 0; n < 40; n++) begin
      addr  = ($urandom_range(0, 7) == 0) ? 32'(DEPTH * 4 - 4 * int'($urandom_range(1, 4)))
                                          : 32'($urandom_range(0, DEPTH - 1) * 4);
      len   = 8'($urandom_range(0, 7));
      sel   = int'($urandom_range(0, 9));
      burst = (sel < 4) ? 2'b00 : (sel < 9) ? 2'b01 : 2'($urandom_range(2, 3));
      size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      id    = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        clear_beats();
        for (int i = 0; i <= int'(len); i++) push_beat($urandom, 4'($urandom), i == int'(len));
        exp = model_write(addr, len, burst, size);
        do_write(addr, id, len, burst, size, br, bi);
        checks++;
        if ({br, bi} !== {exp, id}) begin
          failures++;
          $display("[TB] FAIL rand_bresp[%0d]: got %b/%h, required %b/%h (addr=%h len=%0d burst=%b size=%0d)",
                   n, br, bi, exp, id, addr, len, burst, size);
        end
      end else begin
        model_read(addr, id, len, burst, size);
        do_read(addr, id, len, burst, size, $urandom);
        checks++;
        if (rd_q != exp_q) begin
          failures++;
          $display("[TB] FAIL rand_read[%0d]: got %0d beats first=%h, required %0d beats first=%h (addr=%h burst=%b size=%0d)",
                   n, rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 39'h0, exp_q.size(), exp_q[0], addr, burst, size);
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    slv_ar_valid_i = 1'b0; slv_ar_addr_i = '0; slv_ar_id_i = '0; slv_ar_len_i = '0;
    slv_ar_size_i = 3'd2; slv_ar_burst_i = 2'b01; slv_r_ready_i = 1'b0;
    slv_aw_valid_i = 1'b0; slv_aw_addr_i = '0; slv_aw_id_i = '0; slv_aw_len_i = '0;
    slv_aw_size_i = 3'd2; slv_aw_burst_i = 2'b01;
    slv_w_valid_i = 1'b0; slv_w_data_i = '0; slv_w_strb_i = '0; slv_w_last_i = 1'b0;
    slv_b_ready_i = 1'b0;
    test_reset();
    test_fill();
    test_single_read();
    test_incr_write_read();
    test_fixed_strobe();
    test_backpressure();
    test_errors();
    test_reset_mid_burst();
    test_concurrent();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
